// File: rtl/div_sequencer.sv
// ============================================================================
//  Module      : div_sequencer
//  Description : Radix-2 restoring divider with its sequencing FSM. Serves
//                DIV/DIVU in the execute stage and holds the pipeline on
//                stall_o until quotient (lo_o) and remainder (hi_o) are ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stall_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] rem_q,      rem_d;
  logic [WIDTH-1:0] quo_q,      quo_d;
  logic [WIDTH-1:0] dvsr_q,     dvsr_d;
  logic             neg_quo_q,  neg_quo_d;
  logic             neg_rem_q,  neg_rem_d;
  logic [WIDTH-1:0] lo_q,       lo_d;
  logic [WIDTH-1:0] hi_q,       hi_d;
  logic [WIDTH-1:0] prev_lo_q,  prev_lo_d;
  logic [WIDTH-1:0] prev_hi_q,  prev_hi_d;
  logic             ready_q,    ready_d;
  logic             busy_q,     busy_d;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] fin_lo;
  logic [WIDTH-1:0] fin_hi;

  // Operand conditioning: magnitudes are taken only for signed operations;
  // the most negative value maps onto itself, which is the correct unsigned magnitude.
  always_comb begin
    a_neg = signed_i & a_i[WIDTH-1];
    b_neg = signed_i & b_i[WIDTH-1];
    abs_a = a_neg ? (~a_i + WIDTH'(1)) : a_i;
    abs_b = b_neg ? (~b_i + WIDTH'(1)) : b_i;
  end

  // One restoring step; the extra top bit of the trial difference is the borrow,
  // followed by sign application so the final step can register results directly.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr_q};
    step_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    fin_lo   = neg_quo_q ? (~step_quo + WIDTH'(1)) : step_quo;
    fin_hi   = neg_rem_q ? (~step_rem + WIDTH'(1)) : step_rem;
  end

  // Next-state and next-output computation for the sequencer and datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    prev_lo_d = prev_lo_q;
    prev_hi_d = prev_hi_q;
    ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !cancel_i) begin
          dvsr_d    = abs_b;
          quo_d     = abs_a;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          // Snapshot of the visible results so a cancel in DONE can undo the update.
          prev_lo_d = lo_q;
          prev_hi_d = hi_q;
          if (b_i == '0) begin
            // Divide-by-zero bypasses the iteration entirely.
            state_d = DONE;
            lo_d    = '1;
            hi_d    = a_i;
            ready_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (cancel_i) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = DONE;
            lo_d    = fin_lo;
            hi_d    = fin_hi;
            ready_d = 1'b1;
          end
        end
      end

      DONE: begin
        // start_i is still the same instruction here and is deliberately ignored.
        state_d = IDLE;
        if (cancel_i) begin
          lo_d = prev_lo_q;
          hi_d = prev_hi_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      prev_lo_q <= '0;
      prev_hi_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      prev_lo_q <= prev_lo_d;
      prev_hi_q <= prev_hi_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  // Stall must react in the same cycle as start/cancel, so it is combinational.
  always_comb begin
    stall_o = (((state_q == IDLE) && start_i) || (state_q == RUN)) && !cancel_i;
    ready_o = ready_q && !cancel_i;
    busy_o  = busy_q;
    lo_o    = lo_q;
    hi_o    = hi_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// ============================================================================
//  Module      : tb_div_sequencer
//  Description : Self-checking bench for div_sequencer (WIDTH = 32) with an
//                arithmetic reference model and directed plus random cases.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         signed_i;
  logic         cancel_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         stall_o;
  logic         ready_o;
  logic         busy_o;
  logic [W-1:0] lo_o;
  logic [W-1:0] hi_o;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] last_lo;
  logic [W-1:0] last_hi;

  div_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .cancel_i (cancel_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .lo_o     (lo_o),
    .hi_o     (hi_o)
  );

  always #5 clk = ~clk;

  // Reference: divide magnitudes with native operators, then apply signs.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    ua = (s && a[31]) ? (32'd0 - a) : a;
    ub = (s && b[31]) ? (32'd0 - b) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (s && (a[31] ^ b[31])) q = 32'd0 - q;
    if (s && a[31])           r = 32'd0 - r;
    return {q, r};
  endfunction

  task automatic check32(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a division in an IDLE cycle and returns in its DONE cycle (start still high).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input string tag);
    logic [63:0] e;
    int n, stalls, exp_lat;
    bit got;
    e       = ref_div(a, b, s);
    exp_lat = (b == 32'd0) ? 1 : W + 1;
    a_i = a; b_i = b; signed_i = s; start_i = 1'b1; cancel_i = 1'b0;
    #1;
    n = 0; stalls = 0; got = 1'b0;
    while (!got && n < 100) begin
      if (stall_o) stalls++;
      @(posedge clk); #1;
      n++;
      if (ready_o) got = 1'b1;
    end
    check32({31'd0, got}, 32'd1, {tag, ".ready_seen"});
    check32(n,           exp_lat,   {tag, ".latency"});
    check32(stalls,      exp_lat,   {tag, ".stall_cycles"});
    check32(lo_o,        e[63:32],  {tag, ".lo"});
    check32(hi_o,        e[31:0],   {tag, ".hi"});
    check32({31'd0, stall_o}, 32'd0, {tag, ".stall_in_done"});
    check32({31'd0, busy_o},  32'd1, {tag, ".busy_in_done"});
    last_lo = e[63:32];
    last_hi = e[31:0];
  endtask

  // Leaves DONE with start dropped once the instruction advances; results must hold.
  task automatic retire(input string tag);
    @(posedge clk); #1;
    start_i  = 1'b0;
    cancel_i = 1'b0;
    #1;
    check32({31'd0, busy_o},  32'd0, {tag, ".idle_busy"});
    check32({31'd0, ready_o}, 32'd0, {tag, ".idle_ready"});
    check32(lo_o, last_lo, {tag, ".hold_lo"});
    check32(hi_o, last_hi, {tag, ".hold_hi"});
  endtask

  initial begin
    logic [31:0] ra, rb, save_lo, save_hi;
    logic        rs;
    int          pulses;

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0;
    a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check32({31'd0, stall_o}, 32'd0, "reset.stall");
    check32({31'd0, ready_o}, 32'd0, "reset.ready");
    check32({31'd0, busy_o},  32'd0, "reset.busy");
    check32(lo_o, 32'd0, "reset.lo");
    check32(hi_o, 32'd0, "reset.hi");
    rst = 1'b0;
    @(posedge clk); #1;
    last_lo = '0; last_hi = '0;

    // Directed cases
    issue(32'd100,        32'd7,        1'b0, "divu_100_7");   retire("divu_100_7");
    issue(32'hFFFF_FFF9,  32'd2,        1'b1, "div_m7_2");     retire("div_m7_2");
    issue(32'd7,          32'hFFFF_FFFE, 1'b1, "div_7_m2");    retire("div_7_m2");
    issue(32'h8000_0000,  32'hFFFF_FFFF, 1'b1, "div_ovf");     retire("div_ovf");
    issue(32'hFFFF_FFFF,  32'd1,        1'b0, "divu_max_1");   retire("divu_max_1");
    issue(32'd5,          32'd0,        1'b0, "divu_5_0");     retire("divu_5_0");
    issue(32'hFFFF_FF00,  32'd0,        1'b1, "div_neg_0");    retire("div_neg_0");

    // Back-to-back: second start in the IDLE cycle right after DONE
    issue(32'd100, 32'd7, 1'b0, "b2b_first");
    @(posedge clk); #1;
    check32({31'd0, busy_o}, 32'd0, "b2b.gap_busy");
    issue(32'd9, 32'd3, 1'b0, "b2b_second");
    retire("b2b_second");

    // Cancel in RUN at cycle 10
    a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    cancel_i = 1'b1;
    #1;
    check32({31'd0, stall_o}, 32'd0, "cancel_run.stall_drop");
    @(posedge clk); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    #1;
    check32({31'd0, busy_o}, 32'd0, "cancel_run.idle");
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o) pulses++;
    end
    check32(pulses, 0, "cancel_run.no_ready");
    check32(lo_o, last_lo, "cancel_run.lo_kept");
    check32(hi_o, last_hi, "cancel_run.hi_kept");

    // Cancel in DONE: ready suppressed, visible results revert
    save_lo = last_lo; save_hi = last_hi;
    issue(32'd1000, 32'd33, 1'b0, "cancel_done");
    cancel_i = 1'b1;
    #1;
    check32({31'd0, ready_o}, 32'd0, "cancel_done.ready_forced");
    last_lo = save_lo; last_hi = save_hi;
    retire("cancel_done");

    // Reset in the middle of RUN
    a_i = 32'd12345; b_i = 32'd11; signed_i = 1'b0; start_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    check32({31'd0, stall_o}, 32'd0, "rst_run.stall");
    check32({31'd0, ready_o}, 32'd0, "rst_run.ready");
    check32({31'd0, busy_o},  32'd0, "rst_run.busy");
    check32(lo_o, 32'd0, "rst_run.lo");
    check32(hi_o, 32'd0, "rst_run.hi");
    rst = 1'b0;
    last_lo = '0; last_hi = '0;
    @(posedge clk); #1;

    // Random operands against the reference model
    for (int k = 0; k < 16; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom_range(1, 255);
        2:       rb = 32'd0 - $urandom_range(1, 255);
        default: rb = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF;
      endcase
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs, $sformatf("rand%0d", k));
      retire($sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
